vco_freq_counter: RTL and testbench

- Digital back-end stage directly downstream of the VCO/VGA analog front-end; consumes the VCO's buffered square-wave output.
- Measures VCO frequency by counting rising edges over a programmable gate window of clock cycles.
- Delivers gap-free counts, each tagged with a saturation flag, through a small FIFO with a valid/ready handshake.

---
 rtl/afe_vco_pkg.sv | 18 +
 rtl/vco_sample_fifo.sv | 57 +++++
 rtl/vco_freq_counter.sv | 169 ++++++++++++++++
 tb/tb_vco_freq_counter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/afe_vco_pkg.sv
// Shared types and default widths for the VCO frequency counter back-end.
package afe_vco_pkg;

    localparam int DEF_CNT_W  = 16;
    localparam int DEF_GATE_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

    // Sample as seen by the consumer at the default count width.
    typedef struct packed {
        logic                 sat;
        logic [DEF_CNT_W-1:0] count;
    } sample_t;

endpackage

// File: rtl/vco_sample_fifo.sv
// Small synchronous FIFO holding completed gate-window samples.
// The head is presented combinationally from the registered read pointer; it reads 0 when empty.
module vco_sample_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full_o || do_pop);
    assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/vco_freq_counter.sv
// Counts synchronized VCO rising edges over back-to-back gate windows and
// queues each window's {sat, count} result behind a valid/ready FIFO.
module vco_freq_counter
    import afe_vco_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int GATE_W      = DEF_GATE_W,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              en_i,
    input  logic              vco_i,
    input  logic [GATE_W-1:0] gate_len_i,
    output logic [CNT_W:0]    sample_o,
    output logic              sample_valid_o,
    input  logic              sample_ready_i,
    output logic              overrun_o,
    input  logic              clr_overrun_i,
    output logic              busy_o
);

    typedef struct packed {
        logic             sat;
        logic [CNT_W-1:0] count;
    } win_sample_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   vco_edge;

    state_e            state_q, state_d;
    logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic              sat_q, sat_d;
    logic              overrun_q, overrun_d;

    logic [CNT_W-1:0]  cnt_inc;
    logic              sat_inc;
    logic              terminal;
    logic              push;
    win_sample_t       push_data;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W:0]    fifo_head;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], vco_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign vco_edge = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign terminal = (gate_cnt_q == GATE_W'(1));

    // Saturating count including this cycle's edge; sat records a blocked increment.
    always_comb begin
        cnt_inc = edge_cnt_q;
        sat_inc = sat_q;
        if (vco_edge) begin
            if (edge_cnt_q == CNT_MAX) begin
                sat_inc = 1'b1;
            end else begin
                cnt_inc = edge_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q    <= IDLE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        sat_d      = sat_q;
        case (state_q)
            IDLE: begin
                if (en_i && (gate_len_i != '0)) begin
                    state_d    = COUNT;
                    gate_cnt_d = gate_len_i;
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                end
            end
            COUNT: begin
                if (terminal) begin
                    // Reload immediately so the next window starts without a gap.
                    gate_cnt_d = gate_len_i;
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                    if (!en_i || (gate_len_i == '0)) begin
                        state_d    = IDLE;
                        gate_cnt_d = '0;
                    end
                end else if (!en_i) begin
                    state_d    = IDLE;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                end else begin
                    gate_cnt_d = gate_cnt_q - GATE_W'(1);
                    edge_cnt_d = cnt_inc;
                    sat_d      = sat_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o          = (state_q == COUNT);
        push            = (state_q == COUNT) && terminal;
        push_data.sat   = sat_inc;
        push_data.count = cnt_inc;
    end

    assign pop = sample_ready_i && !fifo_empty;

    // A drop that coincides with a clear still leaves the flag set.
    always_comb begin
        overrun_d = overrun_q;
        if (push && fifo_full && !pop) begin
            overrun_d = 1'b1;
        end else if (clr_overrun_i) begin
            overrun_d = 1'b0;
        end
    end

    vco_sample_fifo #(
        .WIDTH (CNT_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (wb_clk_i),
        .rst_ni      (wb_rst_ni),
        .push_i      (push),
        .push_data_i (push_data),
        .full_o      (fifo_full),
        .pop_i       (pop),
        .pop_data_o  (fifo_head),
        .empty_o     (fifo_empty)
    );

    assign sample_o       = fifo_head;
    assign sample_valid_o = !fifo_empty;
    assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_vco_freq_counter.sv
// Randomized bench for vco_freq_counter: a window/edge-list model predicts every
// FIFO sample for a 16-bit and a 4-bit counter sharing the same stimulus.
module tb_vco_freq_counter;

    localparam int LAT   = 3;
    localparam int DEPTH = 4;
    localparam int MAXC  = 20000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        vco;
    logic [15:0] gate;
    logic        ready;
    logic        clr;

    logic [16:0] smp0;
    logic        val0, ovr0, busy0;
    logic [4:0]  smp1;
    logic        val1, ovr1, busy1;

    always #5 clk = ~clk;

    vco_freq_counter #(.CNT_W(16), .GATE_W(16), .SYNC_STAGES(2), .FIFO_DEPTH(DEPTH)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .en_i(en), .vco_i(vco), .gate_len_i(gate),
        .sample_o(smp0), .sample_valid_o(val0), .sample_ready_i(ready),
        .overrun_o(ovr0), .clr_overrun_i(clr), .busy_o(busy0)
    );

    vco_freq_counter #(.CNT_W(4), .GATE_W(16), .SYNC_STAGES(2), .FIFO_DEPTH(DEPTH)) dut_sat (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .en_i(en), .vco_i(vco), .gate_len_i(gate),
        .sample_o(smp1), .sample_valid_o(val1), .sample_ready_i(ready),
        .overrun_o(ovr1), .clr_overrun_i(clr), .busy_o(busy1)
    );

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          pop_sum  = 0;
    bit          rise_a [MAXC];
    logic        vco_last = 1'b0;
    logic [16:0] mq0 [$];
    logic [4:0]  mq1 [$];
    logic        mov0 = 1'b0;
    logic        mov1 = 1'b0;
    int          term_t [$];
    int          term_n [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Rising edges driven at cycle k are detected LAT cycles later.
    function automatic int count_rises(input int det_lo, input int det_hi);
        int c = 0;
        for (int k = det_lo - LAT; k <= det_hi - LAT; k++) begin
            if (k >= 0 && k < MAXC && rise_a[k]) c++;
        end
        return c;
    endfunction

    task automatic tick();
        logic rdy, clr_v, drop0, drop1;
        int   n;
        if (cyc < MAXC) rise_a[cyc] = vco && !vco_last;
        vco_last = vco;
        rdy      = ready;
        clr_v    = clr;
        if (rst_n && val0 && ready)
            $display("sample cyc=%0d count=%0d sat=%0d", cyc + 1, smp0[15:0], smp0[16]);
        if (rst_n && val0 && ready) pop_sum += int'(smp0[15:0]);
        @(posedge clk);
        cyc++;
        if (rst_n) begin
            drop0 = 1'b0;
            drop1 = 1'b0;
            if (rdy && mq0.size() > 0) mq0.delete(0);
            if (rdy && mq1.size() > 0) mq1.delete(0);
            if (term_t.size() > 0 && term_t[0] == cyc) begin
                n = count_rises(cyc - term_n[0] + 1, cyc);
                term_t.delete(0);
                term_n.delete(0);
                if (mq0.size() < DEPTH) mq0.push_back((n > 65535) ? 17'h1FFFF : {1'b0, 16'(n)});
                else drop0 = 1'b1;
                if (mq1.size() < DEPTH) mq1.push_back((n > 15) ? 5'h1F : {1'b0, 4'(n)});
                else drop1 = 1'b1;
            end
            if (drop0) mov0 = 1'b1; else if (clr_v) mov0 = 1'b0;
            if (drop1) mov1 = 1'b1; else if (clr_v) mov1 = 1'b0;
        end
        #1;
        check_eq("valid0", val0, mq0.size() > 0);
        check_eq("overrun0", ovr0, mov0);
        if (mq0.size() > 0) check_eq("sample0", smp0, mq0[0]);
        check_eq("valid1", val1, mq1.size() > 0);
        check_eq("overrun1", ovr1, mov1);
        if (mq1.size() > 0) check_eq("sample1", smp1, mq1[0]);
    endtask

    task automatic idle(input int n, input logic rdy);
        en    = 1'b0;
        vco   = 1'b0;
        clr   = 1'b0;
        ready = rdy;
        repeat (n) tick();
    endtask

    // rmode: 0 ready low, 1 ready high, 2 ready only on terminal cycles, 3 random ready/clear.
    // endmode: 0 en_i low on the last terminal cycle, 1 gate_len_i 0 instead.
    task automatic run_seq(input int nwin, input int gmin, input int gmax, input int period,
                           input int rmode, input int endmode, output int det_lo, output int det_hi);
        int g [64];
        int t [64];
        int chg [64];
        int e0, acc, ph, w, c;
        e0  = cyc;
        acc = e0 + 1;
        for (int i = 0; i < nwin; i++) begin
            g[i]   = int'($urandom_range(gmax, gmin));
            acc   += g[i];
            t[i]   = acc;
            chg[i] = t[i] - 1 - int'($urandom_range(g[i] - 1, 0));
            term_t.push_back(t[i]);
            term_n.push_back(g[i]);
        end
        det_lo = e0 + 2;
        det_hi = t[nwin-1];
        gate   = 16'(g[0]);
        en     = 1'b1;
        clr    = 1'b0;
        ph     = int'($urandom_range(7, 0));
        w      = 0;
        while (cyc < t[nwin-1]) begin
            c = cyc;
            if (period == 0) vco = 1'($urandom_range(1, 0));
            else begin
                vco = ((ph % period) < (period / 2));
                ph++;
            end
            while (t[w] < c + 1) w++;
            case (rmode)
                0: ready = 1'b0;
                1: ready = 1'b1;
                2: ready = (t[w] == c + 1);
                default: begin
                    ready = 1'($urandom_range(1, 0));
                    clr   = ($urandom_range(7, 0) == 0);
                end
            endcase
            if (c == chg[w]) begin
                if (w < nwin - 1) gate = 16'(g[w+1]);
                else if (endmode == 1) gate = 16'd0;
                else gate = 16'($urandom_range(20, 1));
            end
            if (c == t[nwin-1] - 1 && endmode == 0) en = 1'b0;
            tick();
            if (cyc == e0 + 1) check_eq("busy_in_window", busy0, 1);
        end
        en  = 1'b0;
        clr = 1'b0;
        check_eq("busy_after_windows", busy0, 0);
    endtask

    initial begin
        int lo, hi, e0;
        rst_n = 1'b0;
        en    = 1'b0;
        vco   = 1'b0;
        gate  = 16'd0;
        ready = 1'b0;
        clr   = 1'b0;
        repeat (3) tick();
        check_eq("rst_busy", busy0, 0);
        check_eq("rst_valid", val0, 0);
        check_eq("rst_sample", smp0, 0);
        check_eq("rst_overrun", ovr0, 0);
        #2 rst_n = 1'b1;
        idle(4, 1'b0);

        // Basic count: 100-cycle gate, period-4 VCO gives 25 edges.
        run_seq(1, 100, 100, 4, 0, 0, lo, hi);
        idle(2, 1'b0);
        check_eq("basic_head", smp0, 17'h00019);
        idle(4, 1'b1);
        run_seq(2, 100, 100, 4, 1, 0, lo, hi);
        idle(8, 1'b1);

        // Gap-free windows: sum of samples equals edges seen across the span.
        pop_sum = 0;
        run_seq(10, 7, 7, 2, 1, 0, lo, hi);
        idle(8, 1'b1);
        check_eq("gapfree_sum", pop_sum, count_rises(lo, hi));

        // Randomized windows, gates, VCO and backpressure, including 1-cycle windows.
        for (int i = 0; i < 6; i++) begin
            run_seq(int'($urandom_range(8, 2)), 1, 12, 0, 3, int'($urandom_range(1, 0)), lo, hi);
            idle(int'($urandom_range(6, 1)), 1'($urandom_range(1, 0)));
        end
        idle(8, 1'b1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();

        // Backpressure: six windows into a four-entry FIFO.
        run_seq(6, 10, 10, 3, 0, 0, lo, hi);
        idle(2, 1'b0);
        check_eq("bp_overrun", ovr0, 1);
        check_eq("bp_valid", val0, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_eq("bp_clear", ovr0, 0);
        // Full FIFO with push and pop on the same terminal cycle.
        run_seq(1, 10, 10, 3, 2, 0, lo, hi);
        idle(2, 1'b0);
        check_eq("full_pushpop_overrun", ovr0, 0);
        idle(8, 1'b1);
        check_eq("drained", val0, 0);

        // Saturation in the 4-bit counter.
        run_seq(1, 100, 100, 2, 0, 0, lo, hi);
        idle(2, 1'b0);
        check_eq("sat_head", smp1, 5'h1F);
        check_eq("sat_wide_head", smp0, 17'd50);
        idle(6, 1'b1);

        // Zero gate while enabled must not start a window.
        en   = 1'b1;
        gate = 16'd0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("gate0_idle", busy0, 0);
        end
        en = 1'b0;
        tick();

        // Abort at cycle 50 of a 100-cycle window: nothing is pushed.
        e0   = cyc;
        gate = 16'd100;
        en   = 1'b1;
        ready = 1'b1;
        while (cyc < e0 + 51) begin
            vco = ~vco;
            if (cyc == e0 + 50) en = 1'b0;
            tick();
        end
        check_eq("abort_busy", busy0, 0);
        idle(120, 1'b1);

        // Asynchronous reset mid-window with samples queued.
        run_seq(2, 10, 10, 2, 0, 0, lo, hi);
        gate = 16'd100;
        en   = 1'b1;
        for (int i = 0; i < 30; i++) begin
            vco = ~vco;
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_busy", busy0, 0);
        check_eq("arst_valid", val0, 0);
        check_eq("arst_sample", smp0, 0);
        check_eq("arst_valid_sat", val1, 0);
        mq0.delete();
        mq1.delete();
        term_t.delete();
        term_n.delete();
        mov0 = 1'b0;
        mov1 = 1'b0;
        idle(3, 1'b1);
        #2 rst_n = 1'b1;
        idle(4, 1'b1);
        run_seq(1, 100, 100, 4, 0, 0, lo, hi);
        idle(2, 1'b0);
        check_eq("restart_full_window", smp0, 17'h00019);
        idle(6, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
